// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between instruction fetch and datapath.
// Optional conflict counter enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall,
    output logic [15:0]       conflict_cnt
);

    // active_q keeps every output quiet for the first cycle after reset release
    logic              active_q;
    logic              last_winner_q, last_winner_d;   // 1 = data won last
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [1:0]        tag_q [RD_LAT];                 // {valid, owner}, owner 1 = data
    logic [1:0]        tag_d [RD_LAT];

    always_comb begin
        fetch_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (active_q) begin
            if (fetch_req && data_req) begin
                if (last_winner_q) fetch_gnt = 1'b1;
                else               data_gnt  = 1'b1;
            end else begin
                fetch_gnt = fetch_req;
                data_gnt  = data_req;
            end
        end
    end

    always_comb begin
        last_winner_d = last_winner_q;
        if (data_gnt)       last_winner_d = 1'b1;
        else if (fetch_gnt) last_winner_d = 1'b0;

        ram_addr_d = ram_addr_q;
        if (data_gnt)       ram_addr_d = data_addr;
        else if (fetch_gnt) ram_addr_d = fetch_addr;

        tag_d[0] = {fetch_gnt | (data_gnt & ~data_we), data_gnt};
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q      <= 1'b0;
            last_winner_q <= 1'b0;
            ram_addr_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 2'b00;
        end else begin
            active_q      <= 1'b1;
            last_winner_q <= last_winner_d;
            ram_addr_q    <= ram_addr_d;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign ram_addr     = ram_addr_d;
    assign ram_we       = data_gnt & data_we;
    assign ram_wdata    = active_q ? data_wdata : '0;
    assign fetch_rvalid = tag_q[RD_LAT-1][1] & ~tag_q[RD_LAT-1][0];
    assign data_rvalid  = tag_q[RD_LAT-1][1] &  tag_q[RD_LAT-1][0];
    assign fetch_rdata  = active_q ? ram_rdata : '0;
    assign data_rdata   = active_q ? ram_rdata : '0;
    assign stall        = active_q & fetch_req & ~fetch_gnt;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (active_q && fetch_req && data_req && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) conflict_cnt_q <= '0;
        else        conflict_cnt_q <= conflict_cnt_d;
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each backed by a write-first RAM model whose word at address a starts as 16'h5A00 + a[7:0].
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req, data_req, data_we;
    logic [15:0] fetch_addr, data_addr, data_wdata;

    logic        f_gnt1, f_rv1, d_gnt1, d_rv1, we1, stall1;
    logic [15:0] f_rd1, d_rd1, addr1, wd1, rd1, cc1;
    logic        f_gnt3, f_rv3, d_gnt3, d_rv3, we3, stall3;
    logic [15:0] f_rd3, d_rd3, addr3, wd3, rd3, cc3;

    logic        mem_init;
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(f_gnt1),
        .fetch_rvalid(f_rv1), .fetch_rdata(f_rd1),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(d_gnt1), .data_rvalid(d_rv1), .data_rdata(d_rd1),
        .ram_addr(addr1), .ram_wdata(wd1), .ram_we(we1), .ram_rdata(rd1),
        .stall(stall1), .conflict_cnt(cc1)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(f_gnt3),
        .fetch_rvalid(f_rv3), .fetch_rdata(f_rd3),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(d_gnt3), .data_rvalid(d_rv3), .data_rdata(d_rd3),
        .ram_addr(addr3), .ram_wdata(wd3), .ram_we(we3), .ram_rdata(rd3),
        .stall(stall3), .conflict_cnt(cc3)
    );

    // write-first synchronous RAMs with 1 and 3 cycle read latency
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 16'h5A00 + 16'(i);
                mem3[i] <= 16'h5A00 + 16'(i);
            end
        end else begin
            if (we1) mem1[addr1[7:0]] <= wd1;
            if (we3) mem3[addr3[7:0]] <= wd3;
        end
        pipe1    <= we1 ? wd1 : mem1[addr1[7:0]];
        pipe3[0] <= we3 ? wd3 : mem3[addr3[7:0]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign rd1 = pipe1;
    assign rd3 = pipe3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_cc;
`ifdef MEM_ARB_PERF_CNT_EN
        exp_cc = 16'd6;
`else
        exp_cc = 16'd0;
`endif
        mem_init   = 1'b1;
        reset      = 1'b0;
        fetch_req  = 1'b1;
        data_req   = 1'b0;
        data_we    = 1'b0;
        fetch_addr = 16'h0;
        data_addr  = 16'h0;
        data_wdata = 16'h0;

        // outputs quiet while reset is held, even with a request present
        #3;
        chk("rst_gnt",   {31'b0, f_gnt1}, 32'h0);
        chk("rst_stall", {31'b0, stall1}, 32'h0);
        chk("rst_addr",  {16'b0, addr1},  32'h0);
        fetch_req = 1'b0;
        cyc();
        mem_init = 1'b0;
        cyc();
        reset    = 1'b1;
        data_req = 1'b1;
        data_we  = 1'b1;
        #1;
        chk("first_cyc_gnt", {30'b0, d_gnt1, we1}, 32'h0);
        idle();

        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("idle_outs", {26'b0, f_gnt1, d_gnt1, we1, stall1, f_rv1, d_rv1}, 32'h0);
            chk("idle_addr", {16'b0, addr1}, 32'h0);
        end
        chk("idle_cc", {16'b0, cc1}, 32'h0);

        // fetch stream 0..3
        for (int i = 0; i < 6; i++) begin
            cyc();
            fetch_req  = (i < 4);
            fetch_addr = 16'(i);
            #1;
            chk("fs_gnt",   {31'b0, f_gnt1}, {31'b0, (i < 4)});
            chk("fs_stall", {31'b0, stall1}, 32'h0);
            chk("fs_rv",    {31'b0, f_rv1},  {31'b0, (i >= 1 && i <= 4)});
            if (i >= 1 && i <= 4) chk("fs_rdata", {16'b0, f_rd1}, 32'h5A00 + 32'(i - 1));
        end
        idle();

        // write then read of same address
        cyc();
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0010; data_wdata = 16'hBEEF;
        #1;
        chk("wr_gnt",   {31'b0, d_gnt1}, 32'h1);
        chk("wr_we",    {31'b0, we1},    32'h1);
        chk("wr_addr",  {16'b0, addr1},  32'h0010);
        chk("wr_wdata", {16'b0, wd1},    32'hBEEF);
        cyc();
        data_we = 1'b0;
        #1;
        chk("rd_gnt", {31'b0, d_gnt1}, 32'h1);
        chk("rd_we",  {31'b0, we1},    32'h0);
        chk("rd_rv0", {31'b0, d_rv1},  32'h0);
        cyc();
        idle();
        #1;
        chk("rd_rv1",   {30'b0, d_rv1, f_rv1}, 32'h2);
        chk("rd_rdata", {16'b0, d_rd1},        32'hBEEF);
        chk("hold_addr", {15'b0, addr1, we1},  {15'b0, 16'h0010, 1'b0});

        // both requesting from reset: data first, then alternate
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
            fetch_addr = 16'h0100 + 16'(k);
            data_addr  = 16'h0200 + 16'(k);
            #1;
            chk("rr_gnt",   {30'b0, d_gnt1, f_gnt1}, (k % 2 == 0) ? 32'h2 : 32'h1);
            chk("rr_stall", {31'b0, stall1}, {31'b0, (k % 2 == 0)});
            chk("rr_rv",    {30'b0, d_rv1, f_rv1},
                (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h2 : 32'h1));
            if (k % 2 == 1)       chk("rr_drdata", {16'b0, d_rd1}, 32'h5A00 + 32'(k - 1));
            else if (k >= 2)      chk("rr_frdata", {16'b0, f_rd1}, 32'h5A00 + 32'(k - 1));
        end
        cyc();
        idle();
        #1;
        chk("rr_cc",      {16'b0, cc1},   {16'b0, exp_cc});
        chk("rr_last_rv", {30'b0, d_rv1, f_rv1}, 32'h1);
        chk("rr_last_rd", {16'b0, f_rd1}, 32'h5A05);

        // reset while a data read is in flight
        cyc();
        data_req = 1'b1; data_addr = 16'h0030;
        #1;
        chk("ab_gnt", {31'b0, d_gnt1}, 32'h1);
        cyc();
        idle();
        reset = 1'b0;
        #1;
        chk("ab_rv_rst", {30'b0, d_rv1, d_rv3}, 32'h0);
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("ab_rv_after", {28'b0, d_rv1, f_rv1, d_rv3, f_rv3}, 32'h0);
        end
        fetch_req = 1'b1; data_req = 1'b1;
        #1;
        chk("ab_next_gnt", {30'b0, d_gnt1, f_gnt1}, 32'h2);
        cyc();
        idle();
        repeat (4) cyc();

        // RD_LAT=3: alternating fetch 0x20 / data 0x30 reads
        for (int k = 0; k < 8; k++) begin
            cyc();
            idle();
            if (k < 4) begin
                if (k % 2 == 0) begin fetch_req = 1'b1; fetch_addr = 16'h0020; end
                else            begin data_req  = 1'b1; data_addr  = 16'h0030; end
            end
            #1;
            if (k < 4)
                chk("l3_gnt", {30'b0, d_gnt3, f_gnt3}, (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("l3_rv", {30'b0, d_rv3, f_rv3},
                (k >= 3 && k <= 6) ? (((k - 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
            if (k >= 3 && k <= 6) begin
                if ((k - 3) % 2 == 0) chk("l3_frdata", {16'b0, f_rd3}, 32'h5A20);
                else                  chk("l3_drdata", {16'b0, d_rd3}, 32'h5A30);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port block RAM between two requesters: the program counter's instruction fetch and the datapath's load/store accesses.
- Performs round-robin arbitration and issues one RAM access per cycle.
- Tracks outstanding reads so each read return goes back to its owner.
- Sits between ProgramCounter/Datapath and the block RAM; its stall output freezes the PC while a fetch is pending.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, block RAM read latency in cycles (1..4).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch read request; held until granted.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_gnt  out  1  fetch accepted this cycle.
- fetch_rvalid  out  1  fetch read data valid.
- fetch_rdata  out  DATA_W  fetch read data.
- data_req  in  1  datapath request; held until granted.
- data_we  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_W  datapath address.
- data_wdata  in  DATA_W  write data.
- data_gnt  out  1  datapath request accepted this cycle.
- data_rvalid  out  1  datapath read data valid.
- data_rdata  out  DATA_W  datapath read data.
- ram_addr  out  ADDR_W  block RAM address.
- ram_wdata  out  DATA_W  block RAM write data.
- ram_we  out  1  block RAM write enable.
- ram_rdata  in  DATA_W  block RAM read data.
- stall  out  1  fetch_req high and fetch_gnt low this cycle.
- conflict_cnt  out  16  count of cycles in which both requesters were waiting (see Optional Feature).

Behaviour:
- Reset (reset = 0, asynchronous):
  - Clears tag pipeline, last_winner (reset value = fetch, so data wins the first tie), and conflict_cnt.
  - All outputs are 0 while reset is asserted and in the first cycle after release.
- Grant logic:
  - Combinational from the current req inputs and registered last_winner.
  - Only one request: that requester is granted the same cycle.
  - Both requesting: the requester that is not last_winner is granted; last_winner updates on every grant.
  - No request: no grant; ram_addr holds its last value; ram_we = 0.
- RAM drive:
  - In the grant cycle, ram_addr = the winner's address.
  - ram_we = data_we only when data is granted, and is never asserted for fetch.
  - ram_wdata = data_wdata.
- Read tracking:
  - Each granted read pushes a 2-bit tag {valid, owner} into a shift register RD_LAT deep.
  - RD_LAT cycles after the grant, the tag exits the register:
    - owner = fetch: fetch_rvalid = 1 for one cycle.
    - owner = data: data_rvalid = 1 for one cycle.
  - Both rdata outputs pass ram_rdata straight through; they are meaningful only while the matching rvalid is high.
- Writes:
  - Complete in the grant cycle; no rvalid is produced.
  - A write granted in cycle t followed by a read of the same address granted in t+1 returns the new data (RAM write-first semantics).
- Throughput:
  - One grant per cycle, fully pipelined.
  - Back-to-back grants to the same or alternating requesters are permitted.
- Ordering: read returns are strictly in grant order.
- Handshake:
  - A requester samples gnt at the clock edge and may change address/req in the next cycle.
  - Deasserting req before gnt withdraws the request; this is legal.
- Boundary cases:
  - A single requester held high continuously is granted every cycle with no bubbles.
  - Both held high: grants alternate data, fetch, data, ... starting with data after reset.
  - Reset asserted mid-read: in-flight tags are discarded and no rvalid appears after release.
- Stall: stall = fetch_req & ~fetch_gnt, combinational.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - conflict_cnt increments on each cycle where fetch_req and data_req are both high.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: no counter logic is generated; conflict_cnt is tied to 16'h0000.

Test Plan:
- Reset release, no requests for 5 cycles -> all outputs 0, ram_we never 1.
- fetch_req held with addresses 0x0000..0x0003 advancing on each grant -> fetch_gnt high 4 consecutive cycles; fetch_rvalid high in cycles t+1..t+4 with RAM contents of 0..3; stall low throughout.
- data write 0x0010 <= 0xBEEF, next cycle data read 0x0010 -> ram_we pulse once; data_rvalid one cycle later with 0xBEEF.
- fetch_req and data_req held high together for 6 cycles after reset -> grant order data, fetch, data, fetch, data, fetch; stall high in the 3 data-grant cycles; conflict_cnt = 6 with the macro defined, 0 without.
- Data read granted, then reset asserted before RD_LAT elapses -> no data_rvalid after reset release; next grant goes to data if both request.
- RD_LAT = 3, alternating fetch/data reads to 0x0020/0x0030 -> fetch_rvalid and data_rvalid alternate, each exactly 3 cycles after its grant, with the correct data.
